dm_mem_arbiter: RTL and testbench

//  Shares the single DataMemory port between the CPU MEM stage and a DMA/loader requester.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_arb_grant.sv | 22 ++
 rtl/dm_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_dm_mem_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the DataMemory port arbiter: FSM states and mux owner select.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      G_CPU = 2'd1,
      G_DMA = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_DMA  = 2'd2
   } owner_e;

endpackage

// File: rtl/mem_arb_grant.sv
// Pure winner decode for the DataMemory arbiter; CPU has priority except while a
// bounded DMA burst is in progress or a starvation beat is forced.
module mem_arb_grant
   import mem_arb_pkg::*;
(
   input  logic [1:0] state,
   input  logic       cpu_req,
   input  logic       dma_req,
   input  logic       burst_at_lim,
   input  logic       starve_at_lim,
   output logic       cpu_win,
   output logic       dma_win
);

   logic dma_keeps;

   // A DMA owner keeps the port until its burst budget is spent
   assign dma_keeps = (state == 2'(G_DMA)) && !burst_at_lim;
   assign dma_win   = dma_req && (!cpu_req || dma_keeps || starve_at_lim);
   assign cpu_win   = cpu_req && !dma_win;

endmodule

// File: rtl/dm_mem_arbiter.sv
// Shares the DataMemory port between the CPU MEM stage and a DMA requester.
// Optional DMA starvation guard: define MEM_ARB_STARVE_EN.
module dm_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned AW         = 32,
   parameter int unsigned DW         = 32,
   parameter int unsigned DMA_BURST  = 4,
   parameter int unsigned STARVE_LIM = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_wr,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_ack,
   output logic          cpu_stall,
   input  logic          dma_req,
   input  logic          dma_wr,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic [DW-1:0] dma_rdata,
   output logic          dma_ack,
   output logic          mem_rd,
   output logic          mem_wr,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam int unsigned BW = $clog2(DMA_BURST + 1);

   state_e        state, state_nxt;
   owner_e        owner;
   logic [BW-1:0] burst_cnt, burst_cnt_nxt;
   logic          burst_at_lim;
   logic          starve_at_lim;
   logic          cpu_win, dma_win;

   assign burst_at_lim = (burst_cnt == BW'(DMA_BURST));

`ifdef MEM_ARB_STARVE_EN
   localparam int unsigned SW = $clog2(STARVE_LIM + 1);

   logic [SW-1:0] starve_cnt;

   assign starve_at_lim = dma_req && (starve_cnt == SW'(STARVE_LIM));

   // Counts cycles a pending DMA request goes unserved
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_cnt <= '0;
      end else if (dma_ack) begin
         starve_cnt <= '0;
      end else if (dma_req && (starve_cnt != SW'(STARVE_LIM))) begin
         starve_cnt <= starve_cnt + SW'(1);
      end
   end
`else
   // Guard compiled out; STARVE_LIM stays in the parameter list for a uniform interface
   assign starve_at_lim = 1'b0 & (STARVE_LIM != 0);
`endif

   mem_arb_grant u_grant (
      .state         (state),
      .cpu_req       (cpu_req),
      .dma_req       (dma_req),
      .burst_at_lim  (burst_at_lim),
      .starve_at_lim (starve_at_lim),
      .cpu_win       (cpu_win),
      .dma_win       (dma_win)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         burst_cnt <= '0;
      end else begin
         state     <= state_nxt;
         burst_cnt <= burst_cnt_nxt;
      end
   end

   // Next state records the winner; nothing is granted while reset is held
   always_comb begin
      owner         = OWN_NONE;
      state_nxt     = IDLE;
      burst_cnt_nxt = '0;
      if (reset) begin
         if (cpu_win) begin
            owner     = OWN_CPU;
            state_nxt = G_CPU;
         end else if (dma_win) begin
            owner     = OWN_DMA;
            state_nxt = G_DMA;
            if ((state == G_DMA) && !burst_at_lim) begin
               burst_cnt_nxt = burst_cnt + BW'(1);
            end else begin
               burst_cnt_nxt = burst_cnt;
            end
         end
      end
   end

   always_comb begin
      cpu_ack   = 1'b0;
      dma_ack   = 1'b0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      cpu_rdata = '0;
      dma_rdata = '0;
      case (owner)
         OWN_CPU: begin
            cpu_ack   = 1'b1;
            mem_rd    = !cpu_wr;
            mem_wr    = cpu_wr;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            cpu_rdata = mem_rdata;
         end
         OWN_DMA: begin
            dma_ack   = 1'b1;
            mem_rd    = !dma_wr;
            mem_wr    = dma_wr;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            dma_rdata = mem_rdata;
         end
         default: ;
      endcase
   end

   assign cpu_stall = reset && cpu_req && !cpu_ack;

endmodule

// File: tb/tb_dm_mem_arbiter.sv
// Directed bench for dm_mem_arbiter; honours MEM_ARB_STARVE_EN when defined.
module tb_dm_mem_arbiter;
   import mem_arb_pkg::*;

   logic        clk;
   logic        reset;
   logic        cpu_req, cpu_wr, dma_req, dma_wr;
   logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
   logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        cpu_ack, cpu_stall, dma_ack, mem_rd, mem_wr;

   logic [31:0] dmem [0:255];

   int n_checks = 0;
   int n_fails  = 0;

   dm_mem_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_req   (cpu_req),
      .cpu_wr    (cpu_wr),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_ack   (cpu_ack),
      .cpu_stall (cpu_stall),
      .dma_req   (dma_req),
      .dma_wr    (dma_wr),
      .dma_addr  (dma_addr),
      .dma_wdata (dma_wdata),
      .dma_rdata (dma_rdata),
      .dma_ack   (dma_ack),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // DataMemory stand-in: combinational read, clocked write
   assign mem_rdata = dmem[mem_addr[9:2]];
   always @(posedge clk) if (mem_wr) dmem[mem_addr[9:2]] <= mem_wdata;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1ns later
   task automatic set_cpu(input logic req, input logic wr, input logic [31:0] addr, input logic [31:0] wd);
      cpu_req = req; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wd;
   endtask

   task automatic set_dma(input logic req, input logic wr, input logic [31:0] addr, input logic [31:0] wd);
      dma_req = req; dma_wr = wr; dma_addr = addr; dma_wdata = wd;
   endtask

   task automatic settle;
      #1;
      check("ack_excl", 64'(cpu_ack & dma_ack), 64'(0));
      check("wr_one_ack", 64'(mem_wr & ~(cpu_ack ^ dma_ack)), 64'(0));
   endtask

   initial begin
      for (int i = 0; i < 256; i++) dmem[i] = 32'h0;
      dmem[4] = 32'h1234_5678;
      reset = 1'b0;
      set_cpu(1'b1, 1'b0, 32'h10, 32'h0);
      set_dma(1'b0, 1'b0, 32'h0, 32'h0);

      // 1: held reset masks everything, then a zero-wait CPU read
      @(negedge clk); settle();
      check("rst_cpu_ack", 64'(cpu_ack), 64'(0));
      check("rst_stall", 64'(cpu_stall), 64'(0));
      check("rst_mem_rd", 64'(mem_rd), 64'(0));
      check("rst_mem_addr", 64'(mem_addr), 64'(0));
      check("rst_cpu_rdata", 64'(cpu_rdata), 64'(0));
      reset = 1'b1; settle();
      check("t1_cpu_ack", 64'(cpu_ack), 64'(1));
      check("t1_rdata", 64'(cpu_rdata), 64'h1234_5678);
      check("t1_mem_addr", 64'(mem_addr), 64'h10);
      check("t1_mem_rd", 64'(mem_rd), 64'(1));
      check("t1_stall", 64'(cpu_stall), 64'(0));
      @(negedge clk);
      check("t1_state", 64'(dut.state), 64'(G_CPU));
      set_cpu(1'b0, 1'b0, 32'h0, 32'h0); settle();

      // 2: simultaneous requests from IDLE, CPU keeps winning
      @(negedge clk);
      set_cpu(1'b1, 1'b0, 32'h10, 32'h0);
      set_dma(1'b1, 1'b0, 32'h10, 32'h0);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         settle();
         check("t2_cpu_ack", 64'(cpu_ack), 64'(1));
         check("t2_dma_ack", 64'(dma_ack), 64'(0));
      end
      @(negedge clk);
      set_cpu(1'b0, 1'b0, 32'h0, 32'h0); settle();
      check("t2_dma_ack_drop", 64'(dma_ack), 64'(1));
      check("t2_dma_rdata", 64'(dma_rdata), 64'h1234_5678);

      // 3: DMA owns the port, CPU request waits out a 4-beat burst
      @(negedge clk);
      set_cpu(1'b1, 1'b0, 32'h10, 32'h0);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         settle();
         check("t3_dma_ack", 64'(dma_ack), 64'(1));
         check("t3_stall", 64'(cpu_stall), 64'(1));
      end
      @(negedge clk); settle();
      check("t3_cpu_ack", 64'(cpu_ack), 64'(1));
      check("t3_dma_wait", 64'(dma_ack), 64'(0));
      check("t3_stall_end", 64'(cpu_stall), 64'(0));
      @(negedge clk);
      set_cpu(1'b0, 1'b0, 32'h0, 32'h0); settle();
      check("t3_dma_resume", 64'(dma_ack), 64'(1));

      // 4: CPU store then DMA load of the same word
      @(negedge clk);
      set_dma(1'b0, 1'b0, 32'h0, 32'h0);
      set_cpu(1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF); settle();
      check("t4_cpu_ack", 64'(cpu_ack), 64'(1));
      check("t4_mem_wr", 64'(mem_wr), 64'(1));
      check("t4_mem_rd", 64'(mem_rd), 64'(0));
      check("t4_mem_addr", 64'(mem_addr), 64'h20);
      check("t4_mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
      @(negedge clk);
      set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
      set_dma(1'b1, 1'b0, 32'h20, 32'h0); settle();
      check("t4_dma_ack", 64'(dma_ack), 64'(1));
      check("t4_dma_rdata", 64'(dma_rdata), 64'hDEAD_BEEF);
      check("t4_no_wr", 64'(mem_wr), 64'(0));
      check("t4_cpu_rdata", 64'(cpu_rdata), 64'(0));
      @(negedge clk);
      set_dma(1'b0, 1'b0, 32'h0, 32'h0); settle();
      check("t4_idle_addr", 64'(mem_addr), 64'(0));

      // 5: CPU hogs the port for 20 cycles while DMA waits
      @(negedge clk);
      set_cpu(1'b1, 1'b0, 32'h10, 32'h0);
      set_dma(1'b1, 1'b0, 32'h20, 32'h0);
      for (int i = 1; i <= 20; i++) begin
         if (i > 1) @(negedge clk);
         settle();
`ifdef MEM_ARB_STARVE_EN
         if (i <= 8) begin
            check("t5_dma_wait", 64'(dma_ack), 64'(0));
            check("t5_cpu_ack", 64'(cpu_ack), 64'(1));
         end else if (i == 9) begin
            check("t5_forced_ack", 64'(dma_ack), 64'(1));
            check("t5_forced_stall", 64'(cpu_stall), 64'(1));
            check("t5_forced_rdata", 64'(dma_rdata), 64'hDEAD_BEEF);
         end
`else
         check("t5_dma_never", 64'(dma_ack), 64'(0));
         check("t5_cpu_ack", 64'(cpu_ack), 64'(1));
`endif
      end
      @(negedge clk);
      set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
      set_dma(1'b0, 1'b0, 32'h0, 32'h0); settle();

      // 6: async reset in the middle of a DMA burst
      @(negedge clk);
      set_dma(1'b1, 1'b0, 32'h10, 32'h0); settle();
      @(negedge clk); settle();
      @(negedge clk); settle();
      @(negedge clk); settle();
      check("t6_burst_cnt", 64'(dut.burst_cnt), 64'(2));
      check("t6_pre_ack", 64'(dma_ack), 64'(1));
      #1 reset = 1'b0;
      #1;
      check("t6_ack_drop", 64'(dma_ack), 64'(0));
      check("t6_rd_drop", 64'(mem_rd), 64'(0));
      check("t6_addr_drop", 64'(mem_addr), 64'(0));
      @(negedge clk);
      set_dma(1'b0, 1'b0, 32'h0, 32'h0);
      reset = 1'b1; settle();
      check("t6_state", 64'(dut.state), 64'(IDLE));
      check("t6_burst_clr", 64'(dut.burst_cnt), 64'(0));
      @(negedge clk);
      set_cpu(1'b1, 1'b0, 32'h10, 32'h0);
      set_dma(1'b1, 1'b0, 32'h10, 32'h0); settle();
      check("t6_cpu_first", 64'(cpu_ack), 64'(1));
      check("t6_dma_wait", 64'(dma_ack), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end

endmodule
